// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the data-memory target bus: FSM states,
// target indices and the default address-map tag.
package dmem_bus_pkg;

    localparam int NUM_TGT   = 4;
    localparam int TGT_RAM   = 0;
    localparam int TGT_UART  = 1;
    localparam int TGT_TIMER = 2;
    localparam int TGT_GPIO  = 3;

    localparam logic [1:0] DEFAULT_MAP_TAG = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } dmem_state_t;

endpackage

// File: rtl/dmem_addr_decode.sv
// Combinational target decode from the top nibble of the address:
// the upper two bits must match the map tag, the next two pick the target.
import dmem_bus_pkg::*;

module dmem_addr_decode #(
    parameter logic [1:0] MAP_TAG = DEFAULT_MAP_TAG
) (
    input  logic [3:0] i_addr_hi,
    output logic [1:0] o_sel,
    output logic [3:0] o_onehot,
    output logic       o_mapped
);

    assign o_sel    = i_addr_hi[1:0];
    assign o_mapped = (i_addr_hi[3:2] == MAP_TAG);
    assign o_onehot = 4'b0001 << o_sel;

endmodule

// File: rtl/mux4.sv
// Generic N-bit 4:1 selection block.
module mux4 #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_d0,
    input  logic [N-1:0] i_d1,
    input  logic [N-1:0] i_d2,
    input  logic [N-1:0] i_d3,
    input  logic [1:0]   i_sel,
    output logic [N-1:0] o_y
);

    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd0: o_y = i_d0;
            2'd1: o_y = i_d1;
            2'd2: o_y = i_d2;
            2'd3: o_y = i_d3;
            default: o_y = i_d0;
        endcase
    end

endmodule

// File: rtl/dmem_target_demux.sv
// Routes one CPU data-memory request at a time to RAM/UART/timer/GPIO,
// with per-target handshake, registered response and timeout error.
import dmem_bus_pkg::*;

module dmem_target_demux #(
    parameter int         DW      = 32,
    parameter int         AW      = 32,
    parameter logic [1:0] MAP_TAG = DEFAULT_MAP_TAG,
    parameter int         TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW/8-1:0]   req_wstrb,
    output logic              resp_valid,
    output logic [DW-1:0]     resp_rdata,
    output logic              resp_err,
    output logic [3:0]        tgt_req_valid,
    input  logic [3:0]        tgt_req_ready,
    output logic              tgt_we,
    output logic [AW-1:0]     tgt_addr,
    output logic [DW-1:0]     tgt_wdata,
    output logic [DW/8-1:0]   tgt_wstrb,
    input  logic [3:0]        tgt_resp_valid,
    input  logic [4*DW-1:0]   tgt_resp_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    dmem_state_t       r_state;
    logic [1:0]        r_sel;
    logic [7:0]        r_timer;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [DW-1:0]     r_resp_rdata;
    logic [3:0]        r_tgt_req_valid;
    logic              r_tgt_we;
    logic [AW-1:0]     r_tgt_addr;
    logic [DW-1:0]     r_tgt_wdata;
    logic [DW/8-1:0]   r_tgt_wstrb;

    logic [1:0]        w_sel;
    logic [3:0]        w_onehot;
    logic              w_mapped;
    logic [DW-1:0]     w_sel_rdata;
    logic              w_timeout;
    logic [7:0]        w_timer_next;

    dmem_addr_decode #(
        .MAP_TAG(MAP_TAG)
    ) u_decode (
        .i_addr_hi(req_addr[AW-1:AW-4]),
        .o_sel    (w_sel),
        .o_onehot (w_onehot),
        .o_mapped (w_mapped)
    );

    mux4 #(
        .N(DW)
    ) u_rdata_mux (
        .i_d0 (tgt_resp_rdata[0*DW +: DW]),
        .i_d1 (tgt_resp_rdata[1*DW +: DW]),
        .i_d2 (tgt_resp_rdata[2*DW +: DW]),
        .i_d3 (tgt_resp_rdata[3*DW +: DW]),
        .i_sel(r_sel),
        .o_y  (w_sel_rdata)
    );

    assign w_timeout    = (r_timer == TMO_LAST);
    assign w_timer_next = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;

    // Completion is tested before timeout in ISSUE/WAIT, so a coinciding response wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_sel           <= 2'd0;
            r_timer         <= 8'd0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_err      <= 1'b0;
            r_resp_rdata    <= '0;
            r_tgt_req_valid <= 4'b0000;
            r_tgt_we        <= 1'b0;
            r_tgt_addr      <= '0;
            r_tgt_wdata     <= '0;
            r_tgt_wstrb     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_tgt_we    <= req_we;
                        r_tgt_addr  <= req_addr;
                        r_tgt_wdata <= req_wdata;
                        r_tgt_wstrb <= req_wstrb;
                        r_sel       <= w_sel;
                        r_timer     <= 8'd0;
                        r_req_ready <= 1'b0;
                        if (w_mapped) begin
                            r_tgt_req_valid <= w_onehot;
                            r_state         <= ST_ISSUE;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= ST_ERR;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_timer <= w_timer_next;
                    if (tgt_req_ready[r_sel]) begin
                        r_tgt_req_valid <= 4'b0000;
                        r_state         <= ST_WAIT;
                    end else if (w_timeout) begin
                        r_tgt_req_valid <= 4'b0000;
                        r_resp_valid    <= 1'b1;
                        r_resp_err      <= 1'b1;
                        r_resp_rdata    <= '0;
                        r_state         <= ST_ERR;
                    end
                end
                ST_WAIT: begin
                    r_timer <= w_timer_next;
                    if (tgt_resp_valid[r_sel]) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_tgt_we ? '0 : w_sel_rdata;
                        r_state      <= ST_RESP;
                    end else if (w_timeout) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                        r_state      <= ST_ERR;
                    end
                end
                ST_RESP, ST_ERR: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_err      = r_resp_err;
    assign resp_rdata    = r_resp_rdata;
    assign tgt_req_valid = r_tgt_req_valid;
    assign tgt_we        = r_tgt_we;
    assign tgt_addr      = r_tgt_addr;
    assign tgt_wdata     = r_tgt_wdata;
    assign tgt_wstrb     = r_tgt_wstrb;

endmodule

// File: tb/tb_dmem_target_demux.sv
// Directed self-checking bench for dmem_target_demux.
module tb_dmem_target_demux;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [3:0]    tgt_req_valid;
    logic [3:0]    tgt_req_ready;
    logic          tgt_we;
    logic [31:0]   tgt_addr;
    logic [31:0]   tgt_wdata;
    logic [3:0]    tgt_wstrb;
    logic [3:0]    tgt_resp_valid;
    logic [127:0]  tgt_resp_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dmem_target_demux dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .tgt_req_valid (tgt_req_valid),
        .tgt_req_ready (tgt_req_ready),
        .tgt_we        (tgt_we),
        .tgt_addr      (tgt_addr),
        .tgt_wdata     (tgt_wdata),
        .tgt_wstrb     (tgt_wstrb),
        .tgt_resp_valid(tgt_resp_valid),
        .tgt_resp_rdata(tgt_resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total_cnt++;
        if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({resp_valid, resp_err, tgt_req_valid} !== 6'b0) $display("[TB] FAIL reset_strobes: got %b expected 0", {resp_valid, resp_err, tgt_req_valid});
        else pass_cnt++;
        total_cnt++;
        if ({resp_rdata, tgt_addr, tgt_wdata, tgt_wstrb, tgt_we} !== 101'b0) $display("[TB] FAIL reset_regs: rdata %h addr %h wdata %h expected 0", resp_rdata, tgt_addr, tgt_wdata);
        else pass_cnt++;
    endtask

    task automatic test_read_zero_wait();
        tgt_req_ready = 4'b0010;
        req_we = 1'b0; req_addr = 32'h1000_0004; req_wdata = 32'h0; req_wstrb = 4'h0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        total_cnt++;
        if (tgt_req_valid !== 4'b0010) $display("[TB] FAIL uart_req_valid: got %b expected 0010", tgt_req_valid);
        else pass_cnt++;
        total_cnt++;
        if (tgt_addr !== 32'h1000_0004 || req_ready !== 1'b0) $display("[TB] FAIL uart_payload: addr %h ready %b expected 10000004 0", tgt_addr, req_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (tgt_req_valid !== 4'b0000 || resp_valid !== 1'b0) $display("[TB] FAIL uart_after_hs: req_valid %b resp_valid %b expected 0000 0", tgt_req_valid, resp_valid);
        else pass_cnt++;
        tgt_resp_valid = 4'b0010;
        step();
        tgt_resp_valid = 4'b0000;
        tgt_req_ready = 4'b0000;
        total_cnt++;
        if ({resp_valid, resp_err, req_ready} !== 3'b100) $display("[TB] FAIL uart_resp_flags: got %b expected 100", {resp_valid, resp_err, req_ready});
        else pass_cnt++;
        total_cnt++;
        if (resp_rdata !== 32'hDEAD_BEEF) $display("[TB] FAIL uart_rdata: got %h expected deadbeef", resp_rdata);
        else pass_cnt++;
        step();
        total_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL uart_pulse_end: resp_valid %b ready %b expected 0 1", resp_valid, req_ready);
        else pass_cnt++;
    endtask

    task automatic test_write_stall();
        int bad = 0;
        tgt_resp_rdata[31:0] = 32'hCAFE_F00D;
        tgt_req_ready = 4'b0000;
        req_we = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'h1234_5678; req_wstrb = 4'b0011;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF; req_addr = 32'hFFFF_FFFF; req_wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (tgt_req_valid !== 4'b0001 || tgt_we !== 1'b1 || tgt_addr !== 32'h10 ||
                tgt_wdata !== 32'h1234_5678 || tgt_wstrb !== 4'b0011) bad++;
            if (i == 3) tgt_req_ready = 4'b0001;
            step();
        end
        tgt_req_ready = 4'b0000;
        total_cnt++;
        if (bad !== 0) $display("[TB] FAIL write_payload_stable: got %0d bad cycles expected 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (tgt_req_valid !== 4'b0000) $display("[TB] FAIL write_req_drop: got %b expected 0000", tgt_req_valid);
        else pass_cnt++;
        tgt_resp_valid = 4'b0001;
        step();
        tgt_resp_valid = 4'b0000;
        total_cnt++;
        if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'h0) $display("[TB] FAIL write_resp: valid/err %b rdata %h expected 10 00000000", {resp_valid, resp_err}, resp_rdata);
        else pass_cnt++;
        step();
        tgt_resp_rdata[31:0] = 32'hA0A0_0001;
    endtask

    task automatic test_unmapped();
        req_we = 1'b0; req_addr = 32'h8000_0000;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        total_cnt++;
        if (tgt_req_valid !== 4'b0000) $display("[TB] FAIL unmapped_no_req: got %b expected 0000", tgt_req_valid);
        else pass_cnt++;
        total_cnt++;
        if ({resp_valid, resp_err} !== 2'b11 || resp_rdata !== 32'h0) $display("[TB] FAIL unmapped_err: valid/err %b rdata %h expected 11 00000000", {resp_valid, resp_err}, resp_rdata);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({resp_valid, req_ready, tgt_req_valid} !== 6'b010000) $display("[TB] FAIL unmapped_end: got %b expected 010000", {resp_valid, req_ready, tgt_req_valid});
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n = 0;
        tgt_req_ready = 4'b1000;
        req_we = 1'b0; req_addr = 32'h3000_0000;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        while (n < 40) begin
            step();
            n++;
            tgt_req_ready = 4'b0000;
            if (resp_valid === 1'b1) break;
        end
        total_cnt++;
        if (n !== 16) $display("[TB] FAIL timeout_latency: got %0d cycles expected 16", n);
        else pass_cnt++;
        total_cnt++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'h0) $display("[TB] FAIL timeout_err: err %b rdata %h expected 1 00000000", resp_err, resp_rdata);
        else pass_cnt++;
        step();
        tgt_resp_valid = 4'b1000;
        step();
        tgt_resp_valid = 4'b0000;
        total_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL late_resp_ignored: valid %b ready %b expected 0 1", resp_valid, req_ready);
        else pass_cnt++;
    endtask

    task automatic test_crosstalk();
        req_we = 1'b0; req_addr = 32'h0000_0020;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        tgt_req_ready = 4'b0100;
        step();
        total_cnt++;
        if (tgt_req_valid !== 4'b0001) $display("[TB] FAIL xtalk_ready_ignored: got %b expected 0001", tgt_req_valid);
        else pass_cnt++;
        tgt_req_ready = 4'b0001;
        step();
        tgt_req_ready = 4'b0000;
        tgt_resp_valid = 4'b0100;
        step();
        tgt_resp_valid = 4'b0000;
        total_cnt++;
        if (resp_valid !== 1'b0) $display("[TB] FAIL xtalk_resp_ignored: got %b expected 0", resp_valid);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) step();
        tgt_resp_valid = 4'b0001;
        step();
        tgt_resp_valid = 4'b0000;
        total_cnt++;
        if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'hA0A0_0001) $display("[TB] FAIL coincide_resp_wins: valid/err %b rdata %h expected 10 a0a00001", {resp_valid, resp_err}, resp_rdata);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_wait();
        tgt_req_ready = 4'b0100;
        req_we = 1'b1; req_addr = 32'h2000_0008; req_wdata = 32'h5555_AAAA; req_wstrb = 4'b1111;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        tgt_req_ready = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if ({resp_valid, resp_err, tgt_req_valid, tgt_we, tgt_wstrb} !== 11'b0 ||
            {resp_rdata, tgt_addr, tgt_wdata} !== 96'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL midwait_reset: addr %h wdata %h ready %b expected 0 0 1", tgt_addr, tgt_wdata, req_ready);
        else pass_cnt++;
        tgt_resp_valid = 4'b0100;
        step();
        tgt_resp_valid = 4'b0000;
        total_cnt++;
        if (resp_valid !== 1'b0) $display("[TB] FAIL midwait_late_resp: got %b expected 0", resp_valid);
        else pass_cnt++;
        tgt_req_ready = 4'b0001;
        req_we = 1'b0; req_addr = 32'h0000_0040; req_wdata = 32'h0; req_wstrb = 4'h0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        tgt_req_ready = 4'b0000;
        tgt_resp_valid = 4'b0001;
        step();
        tgt_resp_valid = 4'b0000;
        total_cnt++;
        if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'hA0A0_0001) $display("[TB] FAIL post_reset_read: valid/err %b rdata %h expected 10 a0a00001", {resp_valid, resp_err}, resp_rdata);
        else pass_cnt++;
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        tgt_req_ready = 4'b0000; tgt_resp_valid = 4'b0000;
        tgt_resp_rdata = {32'h3333_4444, 32'h7777_2222, 32'hDEAD_BEEF, 32'hA0A0_0001};
        test_reset();
        test_read_zero_wait();
        test_write_stall();
        test_unmapped();
        test_timeout();
        test_crosstalk();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
